// File: rtl/dino_game_ctrl.sv
// -----------------------------------------------------------------------------
// dino_game_ctrl
//
// Game-state controller for a side-scrolling "dinosaur" runner. A free-running
// divider produces one physics tick every TICK_DIV clocks. The dinosaur idles
// until the first button press, runs on the ground, and can jump. A jump rises
// by RISE_STEP per tick up to JUMP_PEAK, then falls by FALL_STEP per tick back
// to the ground. A collision reported by the renderer ends the game and
// freezes the height. The next press restarts the game from the ground.
//
// Optional feature macro: SCORE_EN
//   defined   : score counts physics ticks while the game is running
//               (saturating at 16383) and is cleared when a game restarts
//   undefined : score is tied to zero and no score counter exists
//
// Parameters
//   TICK_DIV  : clock cycles per physics tick (>= 2)
//   JUMP_PEAK : apex height of a jump (1..63)
//   RISE_STEP : height gained per tick while rising (1..63)
//   FALL_STEP : height lost per tick while falling (1..63)
//
// Ports
//   CLK             in   sole clock, rising edge
//   rst_n           in   synchronous active-low reset
//   button_jump     in   jump/start button level, synchronous to CLK
//   collision       in   obstacle overlap flag from the renderer
//   dinosaur_height out  [5:0]  height above ground (registered)
//   game_status     out  1 while running, rising or falling (registered)
//   game_over       out  1 while the game is over (registered)
//   score           out  [13:0] elapsed-tick score (registered)
// -----------------------------------------------------------------------------
module dino_game_ctrl #(
  parameter int TICK_DIV  = 250000,
  parameter int JUMP_PEAK = 40,
  parameter int RISE_STEP = 4,
  parameter int FALL_STEP = 2
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        button_jump,
  input  logic        collision,
  output logic [5:0]  dinosaur_height,
  output logic        game_status,
  output logic        game_over,
  output logic [13:0] score
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_RISE,
    S_FALL,
    S_OVER
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic               w_tick;
  logic               r_btn_prev;
  logic               r_btn_arm;
  logic               w_edge;
  logic [5:0]         r_height;
  logic [5:0]         w_height_nxt;
  logic               r_status;
  logic               r_over;
  logic [6:0]         w_rise_sum;

  // Free-running physics tick divider
  assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  // Button edge detector. r_btn_arm stays clear after reset until the button
  // has been seen released, so a press held through reset never starts a game.
  assign w_edge = button_jump & ~r_btn_prev & r_btn_arm;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_btn_prev <= 1'b0;
      r_btn_arm  <= 1'b0;
    end else begin
      r_btn_prev <= button_jump;
      if (!button_jump) begin
        r_btn_arm <= 1'b1;
      end
    end
  end

  // Rising sum is one bit wider so the clamp to JUMP_PEAK sees any overflow
  assign w_rise_sum = {1'b0, r_height} + 7'(RISE_STEP);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Collision is tested first in every airborne/ground state so it wins over
  // a simultaneous edge or tick and freezes the height where it is.
  always_comb begin
    w_state_nxt  = r_state;
    w_height_nxt = r_height;
    case (r_state)
      S_IDLE: begin
        w_height_nxt = 6'd0;
        if (w_edge) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_height_nxt = 6'd0;
        if (collision) begin
          w_state_nxt = S_OVER;
        end else if (w_edge) begin
          w_state_nxt = S_RISE;
        end
      end
      S_RISE: begin
        if (collision) begin
          w_state_nxt = S_OVER;
        end else if (w_tick) begin
          if (w_rise_sum >= 7'(JUMP_PEAK)) begin
            w_height_nxt = 6'(JUMP_PEAK);
            w_state_nxt  = S_FALL;
          end else begin
            w_height_nxt = w_rise_sum[5:0];
          end
        end
      end
      S_FALL: begin
        if (collision) begin
          w_state_nxt = S_OVER;
        end else if (w_tick) begin
          if (r_height <= 6'(FALL_STEP)) begin
            w_height_nxt = 6'd0;
            w_state_nxt  = S_RUN;
          end else begin
            w_height_nxt = r_height - 6'(FALL_STEP);
          end
        end
      end
      S_OVER: begin
        if (w_edge) begin
          w_state_nxt  = S_RUN;
          w_height_nxt = 6'd0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_height_nxt = 6'd0;
      end
    endcase
  end

  // Status flags are decoded from the next state so they change together
  // with the state register.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_height <= 6'd0;
      r_status <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_height <= w_height_nxt;
      r_status <= (w_state_nxt == S_RUN) || (w_state_nxt == S_RISE) ||
                  (w_state_nxt == S_FALL);
      r_over   <= (w_state_nxt == S_OVER);
    end
  end

  assign dinosaur_height = r_height;
  assign game_status     = r_status;
  assign game_over       = r_over;

`ifdef SCORE_EN
  logic [13:0] r_score;
  logic        w_score_inc;
  logic        w_score_clr;

  // r_status is high exactly while the current state is RUN/RISE/FALL; a
  // collision in that cycle ends the game before the tick can count.
  assign w_score_inc = w_tick & r_status & ~collision;
  assign w_score_clr = (r_state == S_OVER) & w_edge;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_score <= 14'd0;
    end else if (w_score_clr) begin
      r_score <= 14'd0;
    end else if (w_score_inc && (r_score != 14'h3FFF)) begin
      r_score <= r_score + 14'd1;
    end
  end

  assign score = r_score;
`else
  assign score = 14'd0;
`endif

endmodule

// File: tb/tb_dino_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dino_game_ctrl
//
// Scoreboard bench for dino_game_ctrl. The stimulus process drives inputs on
// the falling edge and pushes the outputs a behavioural game model predicts for
// the following rising edge; a monitor pops and compares after every rising
// edge. Works with and without SCORE_EN defined.
// -----------------------------------------------------------------------------
module tb_dino_game_ctrl;

  localparam int TD    = 4;
  localparam int PEAK  = 40;
  localparam int RSTEP = 4;
  localparam int FSTEP = 2;
  localparam int SMAX  = 16383;

  logic        CLK;
  logic        rst_n;
  logic        button_jump;
  logic        collision;
  logic [5:0]  dinosaur_height;
  logic        game_status;
  logic        game_over;
  logic [13:0] score;

  dino_game_ctrl #(
    .TICK_DIV  (TD),
    .JUMP_PEAK (PEAK),
    .RISE_STEP (RSTEP),
    .FALL_STEP (FSTEP)
  ) dut (
    .CLK             (CLK),
    .rst_n           (rst_n),
    .button_jump     (button_jump),
    .collision       (collision),
    .dinosaur_height (dinosaur_height),
    .game_status     (game_status),
    .game_over       (game_over),
    .score           (score)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int h;
    int st;
    int ov;
    int sc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Behavioural game model: phase 0 idle, 1 on ground, 2 going up,
  // 3 coming down, 4 game over.
  int m_phase    = 0;
  int m_h        = 0;
  int m_sc       = 0;
  int m_cnt      = 0;
  bit m_prev     = 0;
  bit m_released = 0;

  task automatic model_step(input bit r, input bit b, input bit c);
    bit   tick;
    bit   press;
    exp_t e;
    if (!r) begin
      m_phase = 0; m_h = 0; m_sc = 0; m_cnt = 0;
      m_prev = 0; m_released = 0;
    end else begin
      tick  = (m_cnt == TD - 1);
      m_cnt = (m_cnt + 1) % TD;
      press = b && !m_prev && m_released;
      if (!b) m_released = 1;
      m_prev = b;
      case (m_phase)
        0: if (press) m_phase = 1;
        1: begin
          if (c) m_phase = 4;
          else begin
            if (tick && m_sc < SMAX) m_sc++;
            if (press) m_phase = 2;
          end
        end
        2: begin
          if (c) m_phase = 4;
          else if (tick) begin
            if (m_sc < SMAX) m_sc++;
            m_h = m_h + RSTEP;
            if (m_h >= PEAK) begin m_h = PEAK; m_phase = 3; end
          end
        end
        3: begin
          if (c) m_phase = 4;
          else if (tick) begin
            if (m_sc < SMAX) m_sc++;
            m_h = m_h - FSTEP;
            if (m_h <= 0) begin m_h = 0; m_phase = 1; end
          end
        end
        default: if (press) begin m_phase = 1; m_h = 0; m_sc = 0; end
      endcase
    end
    e.h  = m_h;
    e.st = (m_phase >= 1 && m_phase <= 3) ? 1 : 0;
    e.ov = (m_phase == 4) ? 1 : 0;
`ifdef SCORE_EN
    e.sc = m_sc;
`else
    e.sc = 0;
`endif
    q.push_back(e);
  endtask

  task automatic step(input bit r, input bit b, input bit c);
    @(negedge CLK);
    rst_n       = r;
    button_jump = b;
    collision   = c;
    model_step(r, b, c);
  endtask

  task automatic run(input int n, input bit b, input bit c);
    for (int i = 0; i < n; i++) step(1'b1, b, c);
  endtask

  task automatic press_release();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  // Monitor: every rising edge with an outstanding prediction is checked
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("height",      int'(dinosaur_height), e.h);
        check("game_status", int'(game_status),     e.st);
        check("game_over",   int'(game_over),       e.ov);
        check("score",       int'(score),           e.sc);
      end
    end
  end

  initial begin
    int guard;
    bit b;
    rst_n       = 1'b0;
    button_jump = 1'b0;
    collision   = 1'b0;

    // Reset, collisions ignored while idle
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b1);

    // Start, then a full jump with a stray press mid-air
    press_release();
    run(5, 1'b0, 1'b0);
    press_release();
    run(30, 1'b0, 1'b0);
    press_release();
    run(150, 1'b0, 1'b0);

    // Jump, collide at height 24 while rising with a simultaneous press
    press_release();
    guard = 0;
    while (!(m_phase == 2 && m_h == 24) && guard < 200) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("reach_h24", m_h, 24);
    step(1'b1, 1'b1, 1'b1);
    run(50, 1'b0, 1'b0);
    run(10, 1'b0, 1'b1);

    // Restart from game over, score restarts
    press_release();
    run(20, 1'b0, 1'b0);

    // Hold the button while falling, reset at height 12 with it held
    press_release();
    guard = 0;
    while (!(m_phase == 3 && m_h == 12) && guard < 400) begin
      step(1'b1, m_phase == 3, 1'b0);
      guard++;
    end
    check("reach_h12", m_h, 12);
    step(1'b0, 1'b1, 1'b0);
    run(10, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    press_release();
    run(10, 1'b0, 1'b0);

    // Randomized play
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) b = ~b;
      step($urandom_range(0, 999) != 0, b, $urandom_range(0, 99) < 2);
    end

    // Long run to score saturation
    step(1'b0, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0);
    press_release();
    run(SMAX * TD + 60, 1'b0, 1'b0);
    press_release();
    run(200, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    run(5, 1'b0, 1'b0);

    repeat (3) @(posedge CLK);
    #2;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
